// File: rtl/mem_dma_if.sv
// Split read/write memory port: registered read data one cycle after re,
// writes committed on the clock edge that ends a cycle with we high.
interface mem_dma_if;
    logic [15:0] raddr;
    logic        re;
    logic [15:0] rdata;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic        we;

    modport master (output raddr, re, waddr, wdata, we, input rdata);
    modport slave  (input raddr, re, waddr, wdata, we, output rdata);
endinterface

// File: rtl/mem_dma.sv
// Block-transfer initiator: copies src->dst or fills dst with a constant,
// one word per cycle, over a dedicated split read/write memory port.
module mem_dma (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [15:0]      src,
    input  logic [15:0]      dst,
    input  logic [15:0]      len,
    input  logic [15:0]      fill_data,
    output logic             busy,
    output logic             done,
    mem_dma_if.master        mem
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state_reg, state_next;
    logic        mode_reg, mode_next;
    logic [15:0] fill_reg, fill_next;
    logic [15:0] rd_left_reg, rd_left_next;
    logic [15:0] wr_left_reg, wr_left_next;
    logic [15:0] wptr_reg, wptr_next;
    logic [15:0] raddr_reg, raddr_next;
    logic        re_reg, re_next;
    logic [15:0] waddr_reg, waddr_next;
    logic        we_reg, we_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            mode_reg    <= 1'b0;
            fill_reg    <= 16'd0;
            rd_left_reg <= 16'd0;
            wr_left_reg <= 16'd0;
            wptr_reg    <= 16'd0;
            raddr_reg   <= 16'd0;
            re_reg      <= 1'b0;
            waddr_reg   <= 16'd0;
            we_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mode_reg    <= mode_next;
            fill_reg    <= fill_next;
            rd_left_reg <= rd_left_next;
            wr_left_reg <= wr_left_next;
            wptr_reg    <= wptr_next;
            raddr_reg   <= raddr_next;
            re_reg      <= re_next;
            waddr_reg   <= waddr_next;
            we_reg      <= we_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    // rd_left/wr_left count accesses still to be issued after the ones
    // already presented on the registered outputs.
    always_comb begin
        state_next   = state_reg;
        mode_next    = mode_reg;
        fill_next    = fill_reg;
        rd_left_next = rd_left_reg;
        wr_left_next = wr_left_reg;
        wptr_next    = wptr_reg;
        raddr_next   = raddr_reg;
        re_next      = re_reg;
        waddr_next   = waddr_reg;
        we_next      = we_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    mode_next = mode;
                    fill_next = fill_data;
                    if (len == 16'd0) begin
                        done_next = 1'b1;
                    end else begin
                        busy_next  = 1'b1;
                        state_next = RUN;
                        if (!mode) begin
                            re_next      = 1'b1;
                            raddr_next   = src;
                            rd_left_next = len - 16'd1;
                            wr_left_next = len;
                            wptr_next    = dst;
                        end else begin
                            we_next      = 1'b1;
                            waddr_next   = dst;
                            wptr_next    = dst + 16'd1;
                            rd_left_next = 16'd0;
                            wr_left_next = len - 16'd1;
                        end
                    end
                end
            end

            RUN: begin
                if (!mode_reg) begin
                    if (rd_left_reg != 16'd0) begin
                        raddr_next   = raddr_reg + 16'd1;
                        rd_left_next = rd_left_reg - 16'd1;
                    end else begin
                        re_next    = 1'b0;
                        state_next = DRAIN;
                    end
                    // A read on the bus this cycle lands as a write next cycle.
                    if (re_reg) begin
                        we_next      = 1'b1;
                        waddr_next   = wptr_reg;
                        wptr_next    = wptr_reg + 16'd1;
                        wr_left_next = wr_left_reg - 16'd1;
                    end
                end else begin
                    if (wr_left_reg != 16'd0) begin
                        waddr_next   = wptr_reg;
                        wptr_next    = wptr_reg + 16'd1;
                        wr_left_next = wr_left_reg - 16'd1;
                    end else begin
                        we_next    = 1'b0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end

            DRAIN: begin
                we_next    = 1'b0;
                busy_next  = 1'b0;
                done_next  = 1'b1;
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign mem.raddr = raddr_reg;
    assign mem.re    = re_reg;
    assign mem.waddr = waddr_reg;
    assign mem.we    = we_reg;
    // Copy data passes straight from the read port into the write port.
    assign mem.wdata = we_reg ? (mode_reg ? fill_reg : mem.rdata) : 16'd0;

endmodule
